vme_cmd_responder: RTL and testbench

//  Command-execution end of the simulated-VME command channel. Accepts one command per

---
 rtl/vme_resp_pkg.sv | 42 ++++
 rtl/vme_resp_timer.sv | 31 +++
 rtl/vme_cmd_responder.sv | 204 ++++++++++++++++++++
 tb/tb_vme_cmd_responder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vme_resp_pkg.sv
// Shared types and constants for the VME command responder: FSM state
// encoding, command/status bit positions and the response word packer.
package vme_resp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        ACCESS,
        RESPOND,
        GAP
    } state_t;

    // Command word layout
    localparam int RD_BIT = 25;
    localparam int WR_BIT = 24;
    localparam int ID_MSB = 23;
    localparam int ID_LSB = 16;

    // Response word status flags
    localparam int TMO_BIT = 16;
    localparam int ILL_BIT = 17;

    // Data returned when the register bus never acknowledges
    localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;

    // Width of the shared timer, wide enough for the largest timeout
    localparam int TIMER_W = 16;

    // Build a response word: data in the low half, status flags above it,
    // everything else zero.
    function automatic logic [31:0] pack_response(input logic [15:0] data,
                                                  input logic        tmo,
                                                  input logic        ill);
        logic [31:0] word;
        word          = '0;
        word[15:0]    = data;
        word[TMO_BIT] = tmo;
        word[ILL_BIT] = ill;
        return word;
    endfunction

endpackage

// File: rtl/vme_resp_timer.sv
// Loadable down-counter used by the responder both as the bus-ack timeout
// and as the post-response gap counter. expired is high while the count is 0.
module vme_resp_timer
    import vme_resp_pkg::*;
#(
    parameter int WIDTH = TIMER_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic             enable,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    // Load takes priority; otherwise count down and stick at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/vme_cmd_responder.sv
// Command-execution end of the simulated VME command channel. Takes one
// command per start pulse, performs a single register-bus access and returns
// a 32-bit response word with a one-cycle vme_dat_wr strobe.
// Optional build macro: VME_CMD_LOG_EN enables the cmd_count/err_count
// registers; without it both ports are tied to zero.
module vme_cmd_responder
    import vme_resp_pkg::*;
#(
    parameter logic [7:0] BOARD_ID    = 8'hA8,
    parameter int         TIMEOUT_CYC = 255,
    parameter int         GAP_CYC     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] vme_cmd_reg,
    input  logic [31:0] vme_dat_reg_in,
    output logic        vme_cmd_rd,
    output logic        vme_dat_wr,
    output logic [31:0] vme_dat_reg_out,
    output logic        bus_strobe,
    output logic        bus_write,
    output logic [15:0] bus_addr,
    output logic [15:0] bus_wdata,
    input  logic [15:0] bus_rdata,
    input  logic        bus_ack,
    output logic [15:0] cmd_count,
    output logic [15:0] err_count
);

    // Timer preloads: a preload of N-1 keeps the state for exactly N cycles.
    localparam logic [TIMER_W-1:0] ACCESS_LOAD = TIMER_W'(TIMEOUT_CYC - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD    = (GAP_CYC > 0) ? TIMER_W'(GAP_CYC - 1) : '0;

    state_t               state;
    state_t               state_next;
    logic [RD_BIT:0]      cmd_q;
    logic [15:0]          wdata_q;
    logic [31:0]          resp_q;
    logic                 id_match;
    logic                 legal_rw;
    logic                 timer_load;
    logic [TIMER_W-1:0]   timer_value;
    logic                 timer_enable;
    logic                 timer_expired;
    logic                 unused_inputs;

    // Upper command bits and upper data half carry nothing for this board.
    assign unused_inputs = ^{vme_cmd_reg[31:RD_BIT+1], vme_dat_reg_in[31:16]};

    assign id_match = (cmd_q[ID_MSB:ID_LSB] == BOARD_ID);
    assign legal_rw = cmd_q[RD_BIT] ^ cmd_q[WR_BIT];

    vme_resp_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (timer_load),
        .value   (timer_value),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    // State register; reset drops any bus access immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: ack beats an expiring timeout in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = DECODE;
                end
            end
            DECODE: begin
                if (!id_match) begin
                    state_next = IDLE;
                end else if (legal_rw) begin
                    state_next = ACCESS;
                end else begin
                    state_next = RESPOND;
                end
            end
            ACCESS: begin
                if (bus_ack || timer_expired) begin
                    state_next = RESPOND;
                end
            end
            RESPOND: begin
                state_next = (GAP_CYC == 0) ? IDLE : GAP;
            end
            GAP: begin
                if (timer_expired) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Per-state outputs and timer control; bus fields are zero outside ACCESS.
    always_comb begin
        vme_cmd_rd   = 1'b0;
        vme_dat_wr   = 1'b0;
        bus_strobe   = 1'b0;
        bus_write    = 1'b0;
        bus_addr     = '0;
        bus_wdata    = '0;
        timer_load   = 1'b0;
        timer_value  = ACCESS_LOAD;
        timer_enable = 1'b0;
        case (state)
            IDLE: begin
                vme_cmd_rd = 1'b1;
            end
            DECODE: begin
                timer_load  = 1'b1;
                timer_value = ACCESS_LOAD;
            end
            ACCESS: begin
                bus_strobe   = 1'b1;
                bus_write    = cmd_q[WR_BIT];
                bus_addr     = cmd_q[15:0];
                bus_wdata    = wdata_q;
                timer_enable = 1'b1;
            end
            RESPOND: begin
                vme_dat_wr  = 1'b1;
                timer_load  = 1'b1;
                timer_value = GAP_LOAD;
            end
            GAP: begin
                timer_enable = 1'b1;
            end
            default: begin
                vme_cmd_rd = 1'b0;
            end
        endcase
    end

    // Command capture and response word; the response only changes on the
    // edge entering RESPOND so it holds until the next response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q   <= '0;
            wdata_q <= '0;
            resp_q  <= '0;
        end else begin
            if ((state == IDLE) && start) begin
                cmd_q   <= vme_cmd_reg[RD_BIT:0];
                wdata_q <= vme_dat_reg_in[15:0];
            end
            if ((state == DECODE) && id_match && !legal_rw) begin
                resp_q <= pack_response(16'h0000, 1'b0, 1'b1);
            end
            if (state == ACCESS) begin
                if (bus_ack) begin
                    resp_q <= pack_response(cmd_q[WR_BIT] ? wdata_q : bus_rdata, 1'b0, 1'b0);
                end else if (timer_expired) begin
                    resp_q <= pack_response(TIMEOUT_DATA, 1'b1, 1'b0);
                end
            end
        end
    end

    assign vme_dat_reg_out = resp_q;

`ifdef VME_CMD_LOG_EN
    logic [15:0] cmd_count_q;
    logic [15:0] err_count_q;

    // Activity counters: commands that pass the id check, and error responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_count_q <= '0;
            err_count_q <= '0;
        end else begin
            if ((state == DECODE) && id_match) begin
                cmd_count_q <= cmd_count_q + 16'd1;
            end
            if ((state == RESPOND) && (resp_q[TMO_BIT] || resp_q[ILL_BIT])) begin
                err_count_q <= err_count_q + 16'd1;
            end
        end
    end

    assign cmd_count = cmd_count_q;
    assign err_count = err_count_q;
`else
    assign cmd_count = 16'h0000;
    assign err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_vme_cmd_responder.sv
// Self-checking bench for vme_cmd_responder. A bench-side bus slave acks
// after a chosen number of strobe cycles; expected responses, strobe lengths,
// latencies and counters come from a rule-level model of the command channel.
// Works with and without VME_CMD_LOG_EN.
module tb_vme_cmd_responder;

    localparam int         T_CYC = 8;
    localparam int         G_CYC = 2;
    localparam logic [7:0] BID   = 8'hA8;
`ifdef VME_CMD_LOG_EN
    localparam bit LOG_EN = 1'b1;
`else
    localparam bit LOG_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [31:0] vme_cmd_reg = '0;
    logic [31:0] vme_dat_reg_in = '0;
    logic        vme_cmd_rd;
    logic        vme_dat_wr;
    logic [31:0] vme_dat_reg_out;
    logic        bus_strobe;
    logic        bus_write;
    logic [15:0] bus_addr;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata = '0;
    logic        bus_ack = 1'b0;
    logic [15:0] cmd_count;
    logic [15:0] err_count;

    int          errors = 0;
    int          checks = 0;
    int          model_cmd = 0;
    int          model_err = 0;
    logic [31:0] last_resp = '0;

    vme_cmd_responder #(
        .BOARD_ID    (BID),
        .TIMEOUT_CYC (T_CYC),
        .GAP_CYC     (G_CYC)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .vme_cmd_reg     (vme_cmd_reg),
        .vme_dat_reg_in  (vme_dat_reg_in),
        .vme_cmd_rd      (vme_cmd_rd),
        .vme_dat_wr      (vme_dat_wr),
        .vme_dat_reg_out (vme_dat_reg_out),
        .bus_strobe      (bus_strobe),
        .bus_write       (bus_write),
        .bus_addr        (bus_addr),
        .bus_wdata       (bus_wdata),
        .bus_rdata       (bus_rdata),
        .bus_ack         (bus_ack),
        .cmd_count       (cmd_count),
        .err_count       (err_count)
    );

    always #5 clk = ~clk;

    // Overall time limit so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] expect_count(input int value);
        return LOG_EN ? {16'h0000, 16'(value)} : 32'h0;
    endfunction

    task automatic wait_ready(input string tag);
        int waited;
        waited = 0;
        while (!vme_cmd_rd && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check_output(tag, {31'h0, vme_cmd_rd}, 32'h1);
    endtask

    // Run one command; the slave acks in strobe cycle ack_wait+1.
    task automatic apply_stimulus(input logic [31:0] cmd, input logic [31:0] dat,
                                  input int ack_wait, input logic [15:0] rdata);
        bit          id_ok, is_rd, is_wr, legal, tmo;
        int          exp_strobe, exp_low;
        logic [31:0] exp_resp, got_resp;
        int          strobe_cyc, wr_pulses, wr_cyc, low_cyc;
        logic [15:0] addr_seen, wdata_seen;
        logic        write_seen;
        bit          bus_unstable;

        id_ok      = (cmd[23:16] == BID);
        is_rd      = cmd[25] && !cmd[24];
        is_wr      = cmd[24] && !cmd[25];
        legal      = id_ok && (is_rd || is_wr);
        tmo        = legal && (ack_wait + 1 > T_CYC);
        exp_strobe = !legal ? 0 : (tmo ? T_CYC : ack_wait + 1);
        exp_low    = !id_ok ? 1 : exp_strobe + 2 + G_CYC;
        if (!id_ok)      exp_resp = last_resp;
        else if (!legal) exp_resp = 32'h0002_0000;
        else if (tmo)    exp_resp = 32'h0001_DEAD;
        else if (is_rd)  exp_resp = {16'h0000, rdata};
        else             exp_resp = {16'h0000, dat[15:0]};

        @(negedge clk);
        wait_ready("ready_before_start");
        vme_cmd_reg    = cmd;
        vme_dat_reg_in = dat;
        start          = 1'b1;
        @(negedge clk);
        start          = 1'b0;
        vme_cmd_reg    = $urandom;
        vme_dat_reg_in = $urandom;

        strobe_cyc = 0; wr_pulses = 0; wr_cyc = -1; low_cyc = 0;
        bus_unstable = 1'b0; got_resp = '0;
        addr_seen = '0; wdata_seen = '0; write_seen = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (vme_cmd_rd) break;
            low_cyc++;
            bus_ack   = 1'b0;
            bus_rdata = 16'($urandom);
            if (bus_strobe) begin
                strobe_cyc++;
                if (strobe_cyc == 1) begin
                    addr_seen = bus_addr; write_seen = bus_write; wdata_seen = bus_wdata;
                end else if (bus_addr !== addr_seen || bus_write !== write_seen ||
                             bus_wdata !== wdata_seen) begin
                    bus_unstable = 1'b1;
                end
                if (strobe_cyc == ack_wait + 1) begin
                    bus_ack   = 1'b1;
                    bus_rdata = rdata;
                end
            end else begin
                bus_ack = 1'($urandom_range(0, 1));
            end
            if (vme_dat_wr) begin
                wr_pulses++;
                got_resp = vme_dat_reg_out;
                wr_cyc   = cyc;
            end
            @(negedge clk);
        end
        bus_ack = 1'b0;

        if (id_ok) model_cmd++;
        if (id_ok && (!legal || tmo)) model_err++;

        check_output("wr_pulses", 32'(wr_pulses), id_ok ? 32'd1 : 32'd0);
        check_output("busy_cycles", 32'(low_cyc), 32'(exp_low));
        check_output("strobe_cycles", 32'(strobe_cyc), 32'(exp_strobe));
        check_output("resp_held", vme_dat_reg_out, exp_resp);
        if (id_ok) begin
            check_output("resp_at_wr", got_resp, exp_resp);
            check_output("wr_latency", 32'(wr_cyc), 32'(exp_strobe + 1));
        end
        if (legal) begin
            check_output("bus_addr", {16'h0, addr_seen}, {16'h0, cmd[15:0]});
            check_output("bus_write", {31'h0, write_seen}, {31'h0, is_wr});
            check_output("bus_stable", {31'h0, bus_unstable}, 32'h0);
            if (is_wr) check_output("bus_wdata", {16'h0, wdata_seen}, {16'h0, dat[15:0]});
        end
        check_output("cmd_count", {16'h0, cmd_count}, expect_count(model_cmd));
        check_output("err_count", {16'h0, err_count}, expect_count(model_err));
        last_resp = exp_resp;
    endtask

    initial begin
        int          low, wrs, guard, n;
        logic [31:0] rcmd, rdat;
        logic [7:0]  rid;

        $display("[TB] vme_cmd_responder bench, log counters %0s", LOG_EN ? "on" : "off");

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        check_output("rst_cmd_rd", {31'h0, vme_cmd_rd}, 32'h1);
        check_output("rst_dat_wr", {31'h0, vme_dat_wr}, 32'h0);
        check_output("rst_dat_out", vme_dat_reg_out, 32'h0);
        check_output("rst_bus", {bus_strobe, bus_write, bus_addr, bus_wdata[13:0]}, 32'h0);
        check_output("rst_counts", {cmd_count, err_count}, 32'h0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Directed: read, write, timeout, ack at expiry, illegal, wrong id
        apply_stimulus(32'h02A8_4000, 32'h0000_0000, 3, 16'h1234);
        apply_stimulus(32'h01A8_401C, 32'h0000_00FF, 1, 16'hBEEF);
        apply_stimulus(32'h02A8_1000, 32'h0000_0000, 1000, 16'h5555);
        apply_stimulus(32'h02A8_2002, 32'h0000_0000, T_CYC - 1, 16'hC0DE);
        apply_stimulus(32'h01A8_2004, 32'hFFFF_7777, T_CYC, 16'h0000);
        apply_stimulus(32'h03A8_0000, 32'h0000_1111, 1, 16'h2222);
        apply_stimulus(32'h00A8_0010, 32'h0000_1111, 1, 16'h2222);
        apply_stimulus(32'h0255_0000, 32'h0000_3333, 1, 16'h4444);
        apply_stimulus(32'h02A8_0001, 32'h0000_0000, 0, 16'hA5A5);

        // start held high: one command, next one only after the gap
        @(negedge clk);
        wait_ready("hold_ready");
        vme_cmd_reg = 32'h03A8_0000;
        start       = 1'b1;
        @(negedge clk);
        low = 0; wrs = 0; guard = 0;
        while (!vme_cmd_rd && guard < 50) begin
            if (vme_dat_wr) wrs++;
            low++; guard++;
            @(negedge clk);
        end
        check_output("hold_first_wr", 32'(wrs), 32'd1);
        check_output("hold_busy", 32'(low), 32'(2 + G_CYC));
        @(negedge clk);
        check_output("hold_second_accept", {31'h0, vme_cmd_rd}, 32'h0);
        start = 1'b0;
        wrs = 0; guard = 0;
        while (!vme_cmd_rd && guard < 50) begin
            if (vme_dat_wr) wrs++;
            guard++;
            @(negedge clk);
        end
        check_output("hold_second_wr", 32'(wrs), 32'd1);
        model_cmd += 2;
        model_err += 2;
        last_resp = 32'h0002_0000;
        check_output("hold_cmd_count", {16'h0, cmd_count}, expect_count(model_cmd));
        check_output("hold_resp", vme_dat_reg_out, last_resp);

        // Reset in the middle of a bus access
        @(negedge clk);
        wait_ready("rst_mid_ready");
        vme_cmd_reg = 32'h02A8_2000;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0; guard = 0;
        while (n < 3 && guard < 20) begin
            @(negedge clk);
            if (bus_strobe) n++;
            guard++;
        end
        check_output("strobe_before_reset", {31'h0, bus_strobe}, 32'h1);
        rst_n = 1'b0;
        #1;
        check_output("strobe_async_drop", {31'h0, bus_strobe}, 32'h0);
        check_output("rst_mid_cmd_rd", {31'h0, vme_cmd_rd}, 32'h1);
        check_output("rst_mid_out", vme_dat_reg_out, 32'h0);
        check_output("rst_mid_counts", {cmd_count, err_count}, 32'h0);
        model_cmd = 0; model_err = 0; last_resp = '0;
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(32'h02A8_2000, 32'h0000_0000, 2, 16'h6789);

        // Randomized commands
        for (int i = 0; i < 24; i++) begin
            rid  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : BID;
            rcmd = {6'($urandom), 2'($urandom_range(0, 3)), rid, 16'($urandom)};
            rdat = $urandom;
            apply_stimulus(rcmd, rdat, int'($urandom_range(0, T_CYC + 1)), 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
